// File: rtl/adder_rr_sched_if.sv
//------------------------------------------------------------------------------
// adder_rr_sched_if
//
// Bundles the request, shared-adder and response signals of adder_rr_sched.
//
// Signal summary:
//   req_valid[N_REQ]       requester i has an operand bundle pending
//   req_data[65*N_REQ]     bundle of requester i at [65*i+64 : 65*i]
//   req_ready[N_REQ]       one-hot accept pulse from the scheduler
//   adder_ins[65]          registered operand bus to the shared adder
//   adder_sm_r[10]         adder's registered sum
//   adder_sm_zero_r        adder's registered zero flag
//   rsp_valid / rsp_ready  response handshake
//   rsp_id[ID_W]           requester that owns the response
//   rsp_sum[10], rsp_zero  captured adder result
//   busy                   scheduler is not idle
//
// Modports:
//   master  the environment (requesters, shared adder, response consumer)
//   slave   the scheduler itself
//------------------------------------------------------------------------------
interface adder_rr_sched_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]    req_valid;
    logic [65*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]    req_ready;
    logic [64:0]         adder_ins;
    logic [9:0]          adder_sm_r;
    logic                adder_sm_zero_r;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [ID_W-1:0]     rsp_id;
    logic [9:0]          rsp_sum;
    logic                rsp_zero;
    logic                busy;

    modport master (
        output req_valid, req_data, adder_sm_r, adder_sm_zero_r, rsp_ready,
        input  req_ready, adder_ins, rsp_valid, rsp_id, rsp_sum, rsp_zero, busy
    );

    modport slave (
        input  req_valid, req_data, adder_sm_r, adder_sm_zero_r, rsp_ready,
        output req_ready, adder_ins, rsp_valid, rsp_id, rsp_sum, rsp_zero, busy
    );
endinterface

// File: rtl/adder_rr_sched.sv
//------------------------------------------------------------------------------
// adder_rr_sched
//
// Round-robin scheduler sharing one registered 8-lane byte adder among N_REQ
// requesters. A granted bundle is loaded into adder_ins, the adder registers
// its sum one cycle later, the result is captured and returned tagged with the
// requester index over a valid/ready response port.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   adder_rr_sched_if.slave (request, adder and response signals)
//
// Timing: accept edge (IDLE->ISSUE), ISSUE->CAPTURE, CAPTURE->RESP; rsp_valid
// is high after the third edge. With rsp_ready tied high, grants are 4 cycles
// apart.
//------------------------------------------------------------------------------
module adder_rr_sched #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic           clk,
    input  logic           rst,
    adder_rr_sched_if.slave bus
);
    localparam int BW = 65;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESP
    } state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] gnt_id;

    logic            gnt_hit;
    logic [ID_W-1:0] gnt_idx;
    logic [BW-1:0]   gnt_data;
    logic            hi_hit;
    logic [ID_W-1:0] hi_idx;
    logic [ID_W-1:0] lo_idx;

    // Round-robin pick without a modulo: the lowest valid index at or above
    // rr_ptr wins; if there is none, the search wraps to the lowest valid
    // index overall. Scanning downwards lets the last hit be the lowest.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        gnt_hit = 1'b0;
        hi_hit  = 1'b0;
        hi_idx  = '0;
        lo_idx  = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (bus.req_valid[j]) begin
                gnt_hit = 1'b1;
                lo_idx  = ID_W'(j);
                if (ID_W'(j) >= rr_ptr) begin
                    hi_hit = 1'b1;
                    hi_idx = ID_W'(j);
                end
            end
        end
        gnt_idx = hi_hit ? hi_idx : lo_idx;
    end

    // Bundle mux and one-hot accept. req_ready is forced low during reset so
    // the reset value holds even while requesters are still asserting valid.
    always_comb begin
        gnt_data      = '0;
        bus.req_ready = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (ID_W'(j) == gnt_idx) begin
                gnt_data         = bus.req_data[BW*j +: BW];
                bus.req_ready[j] = !rst && (state == IDLE) && gnt_hit;
            end
        end
    end

    assign bus.busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: every register here, including the wide adder_ins operand
        // register, has a reset value; reset must drop any in-flight operation
        // and force all outputs to known values without waiting for a clock.
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            gnt_id        <= '0;
            bus.adder_ins <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_sum   <= '0;
            bus.rsp_zero  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of statement order.
            case (state)
                IDLE: begin
                    if (gnt_hit) begin
                        bus.adder_ins <= gnt_data;
                        gnt_id        <= gnt_idx;
                        rr_ptr        <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                        state         <= ISSUE;
                    end
                end
                // Adder settles this cycle and registers its sum on the closing edge.
                ISSUE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    bus.rsp_sum   <= bus.adder_sm_r;
                    bus.rsp_zero  <= bus.adder_sm_zero_r;
                    bus.rsp_id    <= gnt_id;
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
